// File: rtl/a2_ctrl.sv
// rtl/a2_ctrl.sv - round-robin arbiter and sequencer sharing one a2 compute unit between two requesters
module a2_ctrl #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [3:0] unit_a,
    output logic [3:0] unit_b,
    input  logic [3:0] unit_ans1,
    input  logic [3:0] unit_ans2,
    input  logic [3:0] unit_ans3,
    output logic [3:0] res1,
    output logic [3:0] res2,
    output logic [3:0] res3,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic [7:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] unit_a_q, unit_a_d;
    logic [3:0] unit_b_q, unit_b_d;
    logic [3:0] res1_q, res1_d;
    logic [3:0] res2_q, res2_d;
    logic [3:0] res3_q, res3_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] ops_q, ops_d;
    logic       win;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
    end

    always_comb begin
        state_d  = state_q;
        unit_a_d = unit_a_q;
        unit_b_d = unit_b_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
        res3_d   = res3_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ops_d    = ops_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d  = win;
                    unit_a_d = win ? a1 : a0;
                    unit_b_d = win ? b1 : b0;
                    cnt_d    = CNT_INIT;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res1_d  = unit_ans1;
                    res2_d  = unit_ans2;
                    res3_d  = unit_ans3;
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                last_d  = grant_q;
                ops_d   = ops_q + 8'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset also abandons any in-flight operation without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            unit_a_q <= 4'd0;
            unit_b_q <= 4'd0;
            res1_q   <= 4'd0;
            res2_q   <= 4'd0;
            res3_q   <= 4'd0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 4'd0;
            ops_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            unit_a_q <= unit_a_d;
            unit_b_q <= unit_b_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
            res3_q   <= res3_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ops_q    <= ops_d;
        end
    end

    assign unit_a   = unit_a_q;
    assign unit_b   = unit_b_q;
    assign res1     = res1_q;
    assign res2     = res2_q;
    assign res3     = res3_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = (state_q != S_IDLE);
    assign ops_done = ops_q;

endmodule

// File: tb/tb_a2_ctrl.sv
// tb/tb_a2_ctrl.sv - scoreboard bench for a2_ctrl, one lane at LAT=1 and one at LAT=4
module tb_a2_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int id;
        int a;
        int b;
        int ops;
        int when;
    } exp_t;

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic miss(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout, expected event", nm);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 1 : 4;

        logic       rst = 1'b1;
        logic       r0 = 1'b0, r1 = 1'b0;
        logic [3:0] xa0 = 4'd0, xb0 = 4'd0, xa1 = 4'd0, xb1 = 4'd0;
        logic [3:0] ua, ub, ans1, ans2, ans3, res1, res2, res3;
        logic       d0, d1, bsy;
        logic [7:0] ops;
        logic [7:0] tap;
        logic       fin = 1'b0;
        int         cyc = 0;
        int         m_last = 1;
        int         m_ops = 0;
        int         tot = 0;
        exp_t       q[$];

        a2_ctrl #(.LAT(L)) u_dut (
            .clk(clk), .reset(rst),
            .req0(r0), .a0(xa0), .b0(xb0),
            .req1(r1), .a1(xa1), .b1(xb1),
            .unit_a(ua), .unit_b(ub),
            .unit_ans1(ans1), .unit_ans2(ans2), .unit_ans3(ans3),
            .res1(res1), .res2(res2), .res3(res3),
            .done0(d0), .done1(d1), .busy(bsy), .ops_done(ops)
        );

        // Stub unit: answers become valid LAT edges after the operands change.
        if (L == 1) begin : nodly
            assign tap = {ua, ub};
        end else begin : dly
            logic [7:0] d [L-1];
            always @(posedge clk) begin
                d[0] <= {ua, ub};
                for (int i = 1; i < L - 1; i++) d[i] <= d[i-1];
            end
            assign tap = d[L-2];
        end
        assign ans1 = tap[7:4] + tap[3:0];
        assign ans2 = tap[7:4] - tap[3:0];
        assign ans3 = tap[7:4] & tap[3:0];

        always @(posedge clk) cyc <= cyc + 1;

        task automatic chk_reset(string tag);
            check($sformatf("L%0d %s unit_a", L, tag), ua, 0);
            check($sformatf("L%0d %s unit_b", L, tag), ub, 0);
            check($sformatf("L%0d %s res1", L, tag), res1, 0);
            check($sformatf("L%0d %s res2", L, tag), res2, 0);
            check($sformatf("L%0d %s res3", L, tag), res3, 0);
            check($sformatf("L%0d %s done0", L, tag), d0, 0);
            check($sformatf("L%0d %s done1", L, tag), d1, 0);
            check($sformatf("L%0d %s busy", L, tag), bsy, 0);
            check($sformatf("L%0d %s ops_done", L, tag), ops, 0);
        endtask

        task automatic push(int id, int a, int b, int when);
            exp_t e;
            e.id = id; e.a = a; e.b = b; e.ops = m_ops; e.when = when;
            q.push_back(e);
            m_ops  = (m_ops + 1) % 256;
            m_last = id;
            tot++;
        endtask

        task automatic drop(int who);
            if (who == 0) r0 = 1'b0;
            else r1 = 1'b0;
        endtask

        task automatic wait_done(output int who);
            who = -1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (d0 || d1) begin
                    who = d1 ? 1 : 0;
                    break;
                end
            end
            if (who < 0) begin
                miss($sformatf("L%0d done_wait", L));
            end else begin
                @(posedge clk);
                #1;
                drop(who);
            end
        endtask

        // Called just after an edge with the controller idle; model picks the service order.
        task automatic issue(int kind, int pa0, int pb0, int pa1, int pb1, bit pert);
            int k, who, n, f;
            k   = cyc;
            xa0 = 4'(pa0); xb0 = 4'(pb0); xa1 = 4'(pa1); xb1 = 4'(pb1);
            r0  = (kind != 1);
            r1  = (kind != 0);
            if (kind == 2) begin
                f = (m_last == 0) ? 1 : 0;
                push(f, f ? pa1 : pa0, f ? pb1 : pb0, k + 1 + L);
                push(1 - f, f ? pa0 : pa1, f ? pb0 : pb1, k + 3 + 2 * L);
                n = 2;
            end else begin
                push(kind, kind ? pa1 : pa0, kind ? pb1 : pb0, k + 1 + L);
                n = 1;
            end
            if (pert && kind != 2) begin
                @(posedge clk);
                #1;
                if (kind == 0) begin xa0 = 4'($urandom); xb0 = 4'($urandom); end
                else begin xa1 = 4'($urandom); xb1 = 4'($urandom); end
                if ($urandom_range(0, 1) == 1) drop(kind);
            end
            for (int j = 0; j < n; j++) wait_done(who);
        endtask

        initial begin
            int kind;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk_reset("por");
            @(posedge clk);
            #1 rst = 1'b0;

            r0 = 1'b1; xa0 = 4'd5; xb0 = 4'd6;
            @(posedge clk);
            if (L > 1) @(posedge clk);
            #1 rst = 1'b1; r0 = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk_reset("wait_reset");
            m_last = 1;
            m_ops  = 0;
            @(posedge clk);
            #1;

            issue(0, 3, 1, 0, 0, 1'b0);
            issue(2, 3, 1, 14, 1, 1'b0);
            issue(2, 3, 1, 14, 1, 1'b0);
            issue(1, 0, 0, 14, 1, 1'b1);
            while (tot < 270) begin
                kind = $urandom_range(0, 2);
                issue(kind, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < 50; i++) begin
                if (q.size() == 0) break;
                @(posedge clk);
            end
            check($sformatf("L%0d drain", L), q.size(), 0);
            fin = 1'b1;
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst && (d0 || d1)) begin
                    check($sformatf("L%0d done_onehot", L), int'(d0 & d1), 0);
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL L%0d unexpected_done: got done at cycle %0d, expected none", L, cyc);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("L%0d grant_id", L), d1 ? 1 : 0, e.id);
                        check($sformatf("L%0d res1", L), res1, (e.a + e.b) % 16);
                        check($sformatf("L%0d res2", L), res2, (e.a - e.b + 16) % 16);
                        check($sformatf("L%0d res3", L), res3, e.a & e.b);
                        check($sformatf("L%0d unit_a", L), ua, e.a);
                        check($sformatf("L%0d unit_b", L), ub, e.b);
                        check($sformatf("L%0d done_cycle", L), cyc, e.when);
                        check($sformatf("L%0d busy_done", L), bsy, 1);
                        check($sformatf("L%0d ops_in_done", L), ops, e.ops);
                        @(negedge clk);
                        check($sformatf("L%0d busy_clear", L), bsy, 0);
                        check($sformatf("L%0d done_clear", L), int'(d0 | d1), 0);
                        check($sformatf("L%0d ops_after", L), ops, (e.ops + 1) % 256);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (lane[0].fin && lane[1].fin) break;
        end
        if (!(lane[0].fin && lane[1].fin)) miss("run_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/a2_ctrl.md
Name: a2_ctrl

Overview:
- Arbiter and sequencer that shares one 4-bit a2-style compute unit between two requesters.
- Grants one requester at a time with round-robin fairness and drives that requester's operands onto unit_a/unit_b.
- Waits the unit's fixed latency, captures the unit's three 4-bit answers, and returns them with a one-cycle done pulse to the granted requester.
- Sits between the requester logic and the shared unit; it contains no arithmetic.

Parameters:
- LAT, 1: number of clock cycles from a change on unit_a/unit_b until unit_ans1..3 are valid. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request (level).
- a0  in  4  requester 0 operand a.
- b0  in  4  requester 0 operand b.
- req1  in  1  requester 1 request (level).
- a1  in  4  requester 1 operand a.
- b1  in  4  requester 1 operand b.
- unit_a  out  4  operand a to the shared unit (registered).
- unit_b  out  4  operand b to the shared unit (registered).
- unit_ans1  in  4  unit result 1.
- unit_ans2  in  4  unit result 2.
- unit_ans3  in  4  unit result 3.
- res1  out  4  captured result 1 (registered).
- res2  out  4  captured result 2 (registered).
- res3  out  4  captured result 3 (registered).
- done0  out  1  one-cycle pulse: res1..3 belong to requester 0.
- done1  out  1  one-cycle pulse: res1..3 belong to requester 1.
- busy  out  1  high while an operation is in flight (WAIT or DONE).
- ops_done  out  8  count of completed operations.

Behaviour:
- Reset: state=IDLE; unit_a=unit_b=0; res1..3=0; done0=done1=0; busy=0; ops_done=0; last_grant=1, so req0 wins the first tie; wait counter=0.
- Reset asserted in any state returns all of the above on that edge. An in-flight operation is dropped and produces no done pulse.
- Reset has priority over every other event.
- States:
  - IDLE: at an edge where req0|req1 is high:
    - Choose the winner: if only one request is high, that requester; if both are high, the requester != last_grant.
    - Register the winner's a/b into unit_a/unit_b, record grant id, load counter=LAT-1, busy=1, go to WAIT.
    - With no request: stay in IDLE; unit_a/unit_b hold their values.
  - WAIT: req inputs and operand inputs are ignored.
    - Counter!=0: decrement the counter.
    - Counter==0: capture unit_ans1..3 into res1..3, assert done<grant>, go to DONE.
  - DONE: one cycle; done<grant>=1; busy=1.
    - Next edge: clear done, busy=0, set last_grant=grant, increment ops_done (8-bit, 255 wraps to 0), go to IDLE.
    - req inputs are ignored in DONE.
- Timing: grant at edge G → capture at edge G+LAT → done high during cycle G+LAT..G+LAT+1 → IDLE after G+LAT+1.
  - Earliest next grant is edge G+LAT+2.
  - Per-operation occupancy is LAT+2 cycles.
- Requester protocol:
  - Hold req and operands stable until done; deassert req at the edge that ends its done cycle to avoid a repeat grant.
  - req dropped mid-operation is ignored; the operation completes and done still pulses.
- res1..3 hold their values until the next capture. done0 and done1 are never high together.
- Operands and answers pass through bit-exact (4-bit, no sign handling in this block).

Test Plan:
- Bench stub unit with LAT-stage delay: ans1=a+b, ans2=a-b, ans3=a&b (4-bit wrap).
- LAT=1, reset 3 cycles, then req0=1, a0=3, b0=1 → grant edge G: unit_a=3, unit_b=1; done0 high in cycle G+1; res1=4, res2=2, res3=1; ops_done=1; busy high for 2 cycles.
- LAT=1, req0 and req1 asserted together, a0=3, b0=1, a1=4'hE, b1=1, each held until its done → first done0 (res 4/2/1), then done1 (res F/D/0), then done0 again; strict alternation; done pulses spaced 3 cycles apart.
- LAT=4, req1 only, a1=4'hE, b1=1 → done1 exactly 4 edges after grant (res1=F, res2=D, res3=0); unit_a/unit_b stable throughout WAIT; a1 changed mid-WAIT has no effect.
- Reset asserted during WAIT (LAT=4, second WAIT cycle) → next cycle all outputs at reset values; no done pulse; a fresh req0 is then served normally with ops_done=1.
- Run 256 back-to-back single-requester ops → ops_done wraps to 0; req dropped during WAIT still yields its done pulse.
